// File: rtl/ex_stage.sv
// ex_stage: execute stage behind the ID/EX register.
// Single-cycle ALU operations register their result in one edge. MUL uses a
// shift-add unit over MUL_CYCLES busy cycles, and in_ready is low during that time.
// Optional macro EX_FWD_EN forwards the registered EX/MEM result onto
// operand A/B when the destination index matches.
// Handshake: an instruction is taken on a rising edge with in_valid && in_ready.
// Upstream holds its instruction while in_ready is low. EX/MEM is never
// back-pressured. ex_valid pulses for one cycle per instruction that produces output.
module ex_stage #(
    parameter int DW         = 8,
    parameter int RW         = 3,
    parameter int AW         = 4,
    parameter int MUL_CYCLES = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    opcode,
    input  logic [RW-1:0] operanda,
    input  logic [RW-1:0] operandb,
    input  logic [AW-1:0] dmaddr,
    input  logic [RW-1:0] dest,
    input  logic [DW-1:0] opAdata,
    input  logic [DW-1:0] opBdata,
    output logic          ex_valid,
    output logic [DW-1:0] ex_result,
    output logic [RW-1:0] ex_dest,
    output logic [AW-1:0] ex_dmaddr,
    output logic [DW-1:0] ex_store_data,
    output logic          ex_reg_wr,
    output logic          ex_mem_rd,
    output logic          ex_mem_wr,
    output logic          ex_zero,
    output logic          ex_carry
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t          state;
    logic [DW-1:0]   op_a;
    logic [DW-1:0]   op_b;

    // Multiplier working registers
    logic [2*DW-1:0] mul_prod;
    logic [2*DW-1:0] mul_mcand;
    logic [DW-1:0]   mul_b;
    logic [CW-1:0]   mul_cnt;
    logic [RW-1:0]   mul_dest;
    logic [AW-1:0]   mul_dmaddr;
    logic [DW-1:0]   mul_store;
    logic [2*DW-1:0] mul_step;

    // ALU decode results
    logic [DW-1:0]   alu_res;
    logic            alu_carry;
    logic            alu_valid;
    logic            alu_reg_wr;
    logic            alu_mem_rd;
    logic            alu_mem_wr;
    logic [DW:0]     alu_sum;

    logic            accept;

    assign accept = in_valid && in_ready;

`ifdef EX_FWD_EN
    // The registered EX/MEM outputs are compared here, as they stand at the accepting edge.
    logic fwd_live;
    assign fwd_live = ex_valid && ex_reg_wr;
    assign op_a = (fwd_live && (ex_dest == operanda)) ? ex_result : opAdata;
    assign op_b = (fwd_live && (ex_dest == operandb)) ? ex_result : opBdata;
`else
    logic unused_idx;
    assign unused_idx = ^{operanda, operandb};
    assign op_a = opAdata;
    assign op_b = opBdata;
`endif

    // One shift-add step. Add the shifted multiplicand when the current multiplier LSB is set.
    assign mul_step = mul_prod + (mul_b[0] ? mul_mcand : '0);

    assign alu_sum = {1'b0, op_a} + {1'b0, op_b};

    // Single-cycle ALU result, flags and write enables, decoded from opcode
    always_comb begin
        alu_res    = '0;
        alu_carry  = 1'b0;
        alu_valid  = 1'b1;
        alu_reg_wr = 1'b1;
        alu_mem_rd = 1'b0;
        alu_mem_wr = 1'b0;
        case (opcode)
            4'd1: begin
                alu_res   = alu_sum[DW-1:0];
                alu_carry = alu_sum[DW];
            end
            4'd2: begin
                alu_res   = op_a - op_b;
                alu_carry = (op_a < op_b);
            end
            4'd3: alu_res = op_a & op_b;
            4'd4: alu_res = op_a | op_b;
            4'd5: alu_res = op_a ^ op_b;
            4'd6: alu_res = ~op_a;
            4'd7: begin
                alu_res   = {op_a[DW-2:0], 1'b0};
                alu_carry = op_a[DW-1];
            end
            4'd8: begin
                alu_res   = {1'b0, op_a[DW-1:1]};
                alu_carry = op_a[0];
            end
            4'd9: alu_mem_rd = 1'b1;
            4'd10: begin
                alu_mem_wr = 1'b1;
                alu_reg_wr = 1'b0;
            end
            4'd12: alu_res = op_a;
            default: begin
                // NOP, MUL (handled by the FSM) and opcodes 13-15 produce no output here
                alu_valid  = 1'b0;
                alu_reg_wr = 1'b0;
            end
        endcase
    end

    // Control FSM and EX/MEM register. Data outputs hold on bubbles, and enables clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            in_ready      <= 1'b1;
            ex_valid      <= 1'b0;
            ex_result     <= '0;
            ex_dest       <= '0;
            ex_dmaddr     <= '0;
            ex_store_data <= '0;
            ex_reg_wr     <= 1'b0;
            ex_mem_rd     <= 1'b0;
            ex_mem_wr     <= 1'b0;
            ex_zero       <= 1'b0;
            ex_carry      <= 1'b0;
            mul_prod      <= '0;
            mul_mcand     <= '0;
            mul_b         <= '0;
            mul_cnt       <= '0;
            mul_dest      <= '0;
            mul_dmaddr    <= '0;
            mul_store     <= '0;
        end else begin
            ex_valid  <= 1'b0;
            ex_reg_wr <= 1'b0;
            ex_mem_rd <= 1'b0;
            ex_mem_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && (opcode == 4'd11)) begin
                        mul_prod   <= '0;
                        mul_mcand  <= {{DW{1'b0}}, op_a};
                        mul_b      <= op_b;
                        mul_cnt    <= '0;
                        mul_dest   <= dest;
                        mul_dmaddr <= dmaddr;
                        mul_store  <= op_b;
                        in_ready   <= 1'b0;
                        state      <= MUL_BUSY;
                    end else if (accept && alu_valid) begin
                        ex_valid      <= 1'b1;
                        ex_result     <= alu_res;
                        ex_dest       <= dest;
                        ex_dmaddr     <= dmaddr;
                        ex_store_data <= op_b;
                        ex_reg_wr     <= alu_reg_wr;
                        ex_mem_rd     <= alu_mem_rd;
                        ex_mem_wr     <= alu_mem_wr;
                        ex_zero       <= (alu_res == '0);
                        ex_carry      <= alu_carry;
                    end
                end
                MUL_BUSY: begin
                    mul_prod  <= mul_step;
                    mul_mcand <= mul_mcand << 1;
                    mul_b     <= mul_b >> 1;
                    mul_cnt   <= mul_cnt + CW'(1);
                    if (mul_cnt == CW'(MUL_CYCLES - 1)) begin
                        ex_valid      <= 1'b1;
                        ex_result     <= mul_step[DW-1:0];
                        ex_dest       <= mul_dest;
                        ex_dmaddr     <= mul_dmaddr;
                        ex_store_data <= mul_store;
                        ex_reg_wr     <= 1'b1;
                        ex_zero       <= (mul_step[DW-1:0] == '0);
                        ex_carry      <= |mul_step[2*DW-1:DW];
                        in_ready      <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage.
// Drivers compute the expected EX/MEM record from an arithmetic reference
// model and queue it. A negedge monitor pops and compares on every ex_valid,
// and checks bubble behaviour otherwise.
module tb_ex_stage;
    localparam int DW = 8;
    localparam int RW = 3;
    localparam int AW = 4;
    localparam int EW = DW + RW + AW + DW + 5;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    opcode;
    logic [RW-1:0] operanda;
    logic [RW-1:0] operandb;
    logic [AW-1:0] dmaddr;
    logic [RW-1:0] dest;
    logic [DW-1:0] opAdata;
    logic [DW-1:0] opBdata;
    logic          ex_valid;
    logic [DW-1:0] ex_result;
    logic [RW-1:0] ex_dest;
    logic [AW-1:0] ex_dmaddr;
    logic [DW-1:0] ex_store_data;
    logic          ex_reg_wr;
    logic          ex_mem_rd;
    logic          ex_mem_wr;
    logic          ex_zero;
    logic          ex_carry;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    // Model view of the outputs currently registered, used for forwarding
    logic          prev_v;
    logic          prev_wr;
    logic [RW-1:0] prev_dest;
    logic [DW-1:0] prev_res;

    logic [DW-1:0] last_res;

    ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .operanda(operanda), .operandb(operandb),
        .dmaddr(dmaddr), .dest(dest), .opAdata(opAdata), .opBdata(opBdata),
        .ex_valid(ex_valid), .ex_result(ex_result), .ex_dest(ex_dest),
        .ex_dmaddr(ex_dmaddr), .ex_store_data(ex_store_data),
        .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .ex_zero(ex_zero), .ex_carry(ex_carry)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<2000000", $time);
        $fatal(1, "watchdog");
    end

    // Reference model: expected record {result, dest, dmaddr, store, reg_wr, mem_rd, mem_wr, zero, carry}
    function automatic logic [EW-1:0] model(input int op, input int a, input int b,
                                            input int d, input int ma);
        int res;
        int c;
        int rw;
        int rd;
        int mw;
        logic [DW-1:0] r8;
        logic [DW-1:0] b8;
        logic [RW-1:0] d3;
        logic [AW-1:0] m4;
        res = 0; c = 0; rw = 1; rd = 0; mw = 0;
        case (op)
            1:  begin res = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            2:  begin res = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            3:  res = a & b;
            4:  res = a | b;
            5:  res = a ^ b;
            6:  res = 255 - a;
            7:  begin res = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
            8:  begin res = a / 2; c = a % 2; end
            9:  rd = 1;
            10: begin mw = 1; rw = 0; end
            11: begin res = (a * b) % 256; c = (a * b > 255) ? 1 : 0; end
            12: res = a;
            default: rw = 0;
        endcase
        r8 = res[DW-1:0];
        b8 = b[DW-1:0];
        d3 = d[RW-1:0];
        m4 = ma[AW-1:0];
        return {r8, d3, m4, b8, rw[0], rd[0], mw[0], (res == 0), c[0]};
    endfunction

    function automatic int eff(input int idx, input int data);
`ifdef EX_FWD_EN
        if (prev_v && prev_wr && (int'(prev_dest) == idx)) return int'(prev_res);
`endif
        return data;
    endfunction

    function automatic logic [EW-1:0] actual();
        return {ex_result, ex_dest, ex_dmaddr, ex_store_data,
                ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_zero, ex_carry};
    endfunction

    task automatic check_ready(input string name, input logic want);
        checks++;
        if (in_ready !== want) begin
            errors++;
            $display("FAIL %s: in_ready=%b required=%b t=%0t", name, in_ready, want, $time);
        end
    endtask

    // Driver: present one instruction in IDLE and track the model outputs.
    // With hold set, a MUL keeps in_valid high with an ADD while busy.
    task automatic issue(input int op, input int ra, input int rb, input int d,
                         input int ma, input int da, input int db, input bit hold);
        logic [EW-1:0] e;
        bit valid_op;
        opcode = op[3:0]; operanda = ra[RW-1:0]; operandb = rb[RW-1:0];
        dest = d[RW-1:0]; dmaddr = ma[AW-1:0];
        opAdata = da[DW-1:0]; opBdata = db[DW-1:0];
        in_valid = 1'b1;
        check_ready("ready_before_accept", 1'b1);
        e = model(op, eff(ra, da), eff(rb, db), d, ma);
        valid_op = (op >= 1 && op <= 12);
        @(posedge clk); #1;
        if (op == 11) begin
            exp_q.push_back(e);
            prev_v = 1'b0;
            if (hold) opcode = 4'd1;
            else in_valid = 1'b0;
            for (int i = 0; i < 8; i++) begin
                check_ready("mul_busy_ready", 1'b0);
                @(posedge clk); #1;
            end
            check_ready("mul_done_ready", 1'b1);
        end else if (valid_op) begin
            exp_q.push_back(e);
        end
        prev_v = valid_op;
        if (valid_op) begin
            prev_wr   = e[4];
            prev_dest = d[RW-1:0];
            prev_res  = e[EW-1 -: DW];
        end
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        opcode = 4'($urandom_range(0, 15));
        opAdata = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
        prev_v = 1'b0;
    endtask

    // Monitor: compare on ex_valid, and check enables/held result on bubbles
    always @(negedge clk) begin
        if (rst) begin
            last_res = '0;
        end else if (ex_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got=%h required=no ex_valid t=%0t", actual(), $time);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                last_res = e[EW-1 -: DW];
                if (actual() !== e) begin
                    errors++;
                    $display("FAIL ex_record: got=%h required=%h t=%0t", actual(), e, $time);
                end
            end
        end else begin
            checks++;
            if ({ex_reg_wr, ex_mem_rd, ex_mem_wr} !== 3'b000 || ex_result !== last_res) begin
                errors++;
                $display("FAIL bubble: en=%b result=%h required en=000 result=%h t=%0t",
                         {ex_reg_wr, ex_mem_rd, ex_mem_wr}, ex_result, last_res, $time);
            end
        end
    end

    // Reset, directed test plan, random stimulus, drain and report
    initial begin
        int waited;
        rst = 1'b1; in_valid = 1'b0; opcode = '0; operanda = '0; operandb = '0;
        dmaddr = '0; dest = '0; opAdata = '0; opBdata = '0;
        prev_v = 1'b0; prev_wr = 1'b0; prev_dest = '0; prev_res = '0; last_res = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ex_valid, actual(), in_ready} !== {1'b0, {EW{1'b0}}, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got=%h required=%h", {ex_valid, actual(), in_ready},
                     {1'b0, {EW{1'b0}}, 1'b1});
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // MUL aborted by reset in busy cycle 4
        opcode = 4'd11; opAdata = 8'd7; opBdata = 8'd9; dest = 3'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        prev_v = 1'b0; prev_wr = 1'b0; prev_dest = '0; prev_res = '0;
        #1;
        checks++;
        if ({ex_valid, actual(), in_ready} !== {1'b0, {EW{1'b0}}, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_mul: got=%h required=%h", {ex_valid, actual(), in_ready},
                     {1'b0, {EW{1'b0}}, 1'b1});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases: op, ra, rb, dest, dmaddr, A, B, hold
        issue(1, 0, 1, 2, 0, 5, 3, 0);
        issue(1, 0, 1, 5, 1, 8'hFF, 8'h01, 0);
        issue(2, 0, 1, 5, 2, 8'h03, 8'h05, 0);
        issue(8, 0, 1, 5, 3, 8'h01, 8'h00, 0);
        issue(11, 0, 1, 6, 4, 13, 11, 0);
        issue(11, 0, 1, 6, 5, 8'h20, 8'h10, 0);
        issue(9, 0, 1, 4, 4'hA, 8'h11, 8'h22, 0);
        issue(10, 0, 1, 7, 3, 8'h44, 8'h5C, 0);
        issue(1, 0, 1, 3, 0, 5, 3, 0);
        issue(1, 3, 4, 5, 0, 0, 1, 0);
        issue(0, 0, 1, 2, 0, 9, 9, 0);
        idle_cycle();
        issue(11, 0, 1, 3, 0, 6, 7, 0);
        issue(1, 3, 4, 5, 0, 0, 1, 0);
        issue(14, 0, 1, 2, 0, 1, 1, 0);
        issue(11, 1, 2, 6, 0, 9, 9, 1);
        issue(1, 1, 2, 6, 0, 9, 9, 0);
        idle_cycle();

        // Random stimulus with a narrow register range to provoke forwarding hits
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 9) < 2) idle_cycle();
            else issue($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 15),
                       $urandom_range(0, 255), $urandom_range(0, 255), 0);
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
